sig_event_counter: RTL and testbench
====================================

// Module: sig_event_counter
// PURPOSE
//  Downstream consumer of the registered sig_out of the dual-flop/AND stage.
//  Debounces that level in the d_clk domain, emits single-cycle rise/fall pulses
//  on confirmed transitions, and counts confirmed rising events in a saturating,
//  software-clearable counter. sig_in is synchronous to d_clk; no synchronizer here.
// PARAMETERS
//  STABLE_CYCLES  4  consecutive samples a new level must hold to be accepted (>=2)
//  CNT_W          8  width of event_cnt
// PORTS
//  d_clk       in   1      clock; all logic on posedge
//  d_rst_n     in   1      reset, synchronous, active-low
//  sig_in      in   1      level from upstream registered stage
//  cnt_clr     in   1      synchronous clear of event_cnt/cnt_sat
//  sig_level   out  1      debounced level (registered)
//  rise_pulse  out  1      1-cycle pulse on confirmed 0->1
//  fall_pulse  out  1      1-cycle pulse on confirmed 1->0
//  event_cnt   out  CNT_W  confirmed rising events, saturating
//  cnt_sat     out  1      1 when event_cnt == all-ones
// BEHAVIOUR
//  Reset: d_rst_n=0 at posedge -> state LOW, stab_cnt=0, all outputs 0; overrides all inputs.
//  FSM (4 states), stab_cnt counts accepted samples of the candidate level:
//   LOW:    sig_in=1 -> CHK_HI, stab_cnt=1; else stay.
//   CHK_HI: sig_in=0 -> LOW, stab_cnt=0 (glitch discarded, no pulse).
//           sig_in=1 & stab_cnt==STABLE_CYCLES-1 -> HIGH, sig_level<=1, rise_pulse<=1.
//           else stab_cnt++.
//   HIGH:   sig_in=0 -> CHK_LO, stab_cnt=1; else stay.
//   CHK_LO: mirror of CHK_HI: sig_in=1 -> HIGH; STABLE_CYCLES lows -> LOW,
//           sig_level<=0, fall_pulse<=1.
//  Latency: pulse visible in the cycle after the STABLE_CYCLES-th consecutive
//   sampling edge of the new level; sig_level changes on that same edge.
//  rise_pulse/fall_pulse are registered, high exactly one cycle, never both at once;
//   min spacing between confirmed edges = STABLE_CYCLES cycles.
//  event_cnt: +1 on the edge that sets rise_pulse; holds at 2^CNT_W-1 (no wrap).
//   cnt_sat = (event_cnt == 2^CNT_W-1), registered together with event_cnt.
//  cnt_clr: event_cnt<=0, cnt_sat<=0; FSM and sig_level unaffected.
//   cnt_clr and confirmed rise on same edge -> event_cnt<=1 (event not lost).
//  Reset mid-CHK_* or in HIGH: candidate abandoned, sig_level->0, no fall_pulse issued.
// TESTING
//  1. d_rst_n=0 two edges with sig_in=1, cnt_clr=1 -> all outputs 0; release, hold
//     sig_in=1 -> rise_pulse 1 cycle after 4th sampling edge, sig_level=1, event_cnt=1.
//  2. sig_in high 3 cycles then low (STABLE_CYCLES=4) -> no rise_pulse, sig_level=0, event_cnt=0.
//  3. sig_in high 10, low 10 cycles -> one rise_pulse, one fall_pulse 4 edges after fall,
//     event_cnt=1; low glitch of 2 cycles inside high period -> no fall_pulse.
//  4. CNT_W=2, five clean pulses -> event_cnt 1,2,3,3,3; cnt_sat=1 from third event on.
//  5. cnt_clr asserted on the edge rise_pulse is set -> event_cnt=1; cnt_clr alone -> 0, cnt_sat=0.
//  6. Assert d_rst_n=0 while sig_level=1 -> next cycle sig_level=0, no fall_pulse,
//     event_cnt=0; sig_in still 1 after release -> new rise after 4 edges.

Source files
------------

// File: rtl/sig_event_counter_if.sv
// rtl/sig_event_counter_if.sv - signal bundle between the upstream level source and the event counter
// Groups the sampled level, the software clear and all debounced/count results.
interface sig_event_counter_if #(
  parameter int CNT_W = 8
);
  logic             sig_in;
  logic             cnt_clr;
  logic             sig_level;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] event_cnt;
  logic             cnt_sat;

  // Source side: drives the level and clear, observes the results.
  modport master (
    output sig_in,
    output cnt_clr,
    input  sig_level,
    input  rise_pulse,
    input  fall_pulse,
    input  event_cnt,
    input  cnt_sat
  );

  // Counter side: consumes the level and clear, produces the results.
  modport slave (
    input  sig_in,
    input  cnt_clr,
    output sig_level,
    output rise_pulse,
    output fall_pulse,
    output event_cnt,
    output cnt_sat
  );
endinterface

// File: rtl/sig_event_counter.sv
// rtl/sig_event_counter.sv - debounced level tracker with edge pulses and saturating rise counter
// A new level is accepted only after STABLE_CYCLES consecutive samples of it.
// Confirmed rising edges are counted in a saturating, software-clearable counter.
module sig_event_counter #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic               d_clk,
  input  logic               d_rst_n,
  sig_event_counter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    ST_CHK_HI = 2'd1,
    ST_HIGH   = 2'd2,
    ST_CHK_LO = 2'd3
  } state_t;

  // Stability counter only needs to reach STABLE_CYCLES-1.
  localparam int SW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [SW-1:0]    STAB_ONE  = SW'(1);
  localparam logic [SW-1:0]    STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  logic [SW-1:0]    stab_cnt;
  logic             sig_level_q;
  logic             rise_q;
  logic             fall_q;
  logic [CNT_W-1:0] event_cnt_q;
  logic             cnt_sat_q;
  logic [CNT_W-1:0] cnt_next;
  logic             confirm_rise;
  logic             confirm_fall;

  // A candidate is confirmed when its final required sample arrives this edge.
  always_comb begin
    confirm_rise = (state == ST_CHK_HI) && bus.sig_in  && (stab_cnt == STAB_LAST);
    confirm_fall = (state == ST_CHK_LO) && !bus.sig_in && (stab_cnt == STAB_LAST);
  end

  // Debounce FSM; level and pulses are registered alongside the state.
  always_ff @(posedge d_clk) begin
    if (!d_rst_n) begin
      state       <= ST_LOW;
      stab_cnt    <= '0;
      sig_level_q <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
    end else begin
      rise_q <= confirm_rise;
      fall_q <= confirm_fall;
      unique case (state)
        ST_LOW: begin
          if (bus.sig_in) begin
            state    <= ST_CHK_HI;
            stab_cnt <= STAB_ONE;
          end
        end
        ST_CHK_HI: begin
          if (!bus.sig_in) begin
            state    <= ST_LOW;
            stab_cnt <= '0;
          end else if (stab_cnt == STAB_LAST) begin
            state       <= ST_HIGH;
            stab_cnt    <= '0;
            sig_level_q <= 1'b1;
          end else begin
            stab_cnt <= stab_cnt + STAB_ONE;
          end
        end
        ST_HIGH: begin
          if (!bus.sig_in) begin
            state    <= ST_CHK_LO;
            stab_cnt <= STAB_ONE;
          end
        end
        ST_CHK_LO: begin
          if (bus.sig_in) begin
            state    <= ST_HIGH;
            stab_cnt <= '0;
          end else if (stab_cnt == STAB_LAST) begin
            state       <= ST_LOW;
            stab_cnt    <= '0;
            sig_level_q <= 1'b0;
          end else begin
            stab_cnt <= stab_cnt + STAB_ONE;
          end
        end
        default: begin
          state    <= ST_LOW;
          stab_cnt <= '0;
        end
      endcase
    end
  end

  // Next counter value: clear wins over increment but keeps a simultaneous rise.
  always_comb begin
    cnt_next = event_cnt_q;
    if (bus.cnt_clr) begin
      cnt_next = confirm_rise ? CNT_ONE : '0;
    end else if (confirm_rise && !(&event_cnt_q)) begin
      cnt_next = event_cnt_q + CNT_ONE;
    end
  end

  // Counter and its saturation flag are registered together so they never disagree.
  always_ff @(posedge d_clk) begin
    if (!d_rst_n) begin
      event_cnt_q <= '0;
      cnt_sat_q   <= 1'b0;
    end else begin
      event_cnt_q <= cnt_next;
      cnt_sat_q   <= &cnt_next;
    end
  end

  assign bus.sig_level  = sig_level_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.event_cnt  = event_cnt_q;
  assign bus.cnt_sat    = cnt_sat_q;

endmodule

// File: tb/tb_sig_event_counter.sv
// tb/tb_sig_event_counter.sv - scoreboard bench for sig_event_counter (8-bit and 2-bit counters)
module tb_sig_event_counter;

  localparam int S = 4;

  logic d_clk;
  logic d_rst_n;
  logic sig_in;
  logic cnt_clr;

  sig_event_counter_if #(.CNT_W(8)) bus8 ();
  sig_event_counter_if #(.CNT_W(2)) bus2 ();

  assign bus8.sig_in  = sig_in;
  assign bus8.cnt_clr = cnt_clr;
  assign bus2.sig_in  = sig_in;
  assign bus2.cnt_clr = cnt_clr;

  sig_event_counter #(.STABLE_CYCLES(S), .CNT_W(8)) dut8 (
    .d_clk   (d_clk),
    .d_rst_n (d_rst_n),
    .bus     (bus8.slave)
  );

  sig_event_counter #(.STABLE_CYCLES(S), .CNT_W(2)) dut2 (
    .d_clk   (d_clk),
    .d_rst_n (d_rst_n),
    .bus     (bus2.slave)
  );

  initial d_clk = 1'b0;
  always #5 d_clk = ~d_clk;

  typedef struct {
    bit lvl;
    bit rise;
    bit fall;
    int c8;
    bit s8;
    int c2;
    bit s2;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mon_cyc  = 0;

  // Reference: samples since reset; a level flips when the last S samples all differ from it.
  bit hist[$];
  bit m_level = 1'b0;
  int m_c8 = 0;
  int m_c2 = 0;

  function automatic void chk(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", nm, mon_cyc, act, exp);
    end
  endfunction

  function automatic int sat_add(int v, int inc, int maxv);
    return (v + inc > maxv) ? maxv : v + inc;
  endfunction

  task automatic model_step(input bit r, input bit s, input bit c);
    exp_t e;
    bit   rise;
    bit   fall;
    bit   all_new;
    rise = 1'b0;
    fall = 1'b0;
    if (!r) begin
      hist.delete();
      m_level = 1'b0;
      m_c8    = 0;
      m_c2    = 0;
    end else begin
      hist.push_back(s);
      if (hist.size() > S) void'(hist.pop_front());
      if (hist.size() == S) begin
        all_new = 1'b1;
        foreach (hist[i]) if (hist[i] == m_level) all_new = 1'b0;
        if (all_new) begin
          if (m_level) fall = 1'b1;
          else         rise = 1'b1;
          m_level = !m_level;
        end
      end
      m_c8 = c ? int'(rise) : sat_add(m_c8, int'(rise), 255);
      m_c2 = c ? int'(rise) : sat_add(m_c2, int'(rise), 3);
    end
    e.lvl  = m_level;
    e.rise = rise;
    e.fall = fall;
    e.c8   = m_c8;
    e.s8   = (m_c8 == 255);
    e.c2   = m_c2;
    e.s2   = (m_c2 == 3);
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit r, input bit s, input bit c);
    @(negedge d_clk);
    d_rst_n = r;
    sig_in  = s;
    cnt_clr = c;
    model_step(r, s, c);
  endtask

  task automatic run(input int n, input bit s);
    for (int i = 0; i < n; i++) cyc(1'b1, s, 1'b0);
  endtask

  // Monitor: each post-edge observation is matched against the oldest expected record.
  initial begin
    exp_t e;
    forever begin
      @(posedge d_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        mon_cyc++;
        chk("sig_level_8",  int'(bus8.sig_level),  int'(e.lvl));
        chk("rise_pulse_8", int'(bus8.rise_pulse), int'(e.rise));
        chk("fall_pulse_8", int'(bus8.fall_pulse), int'(e.fall));
        chk("event_cnt_8",  int'(bus8.event_cnt),  e.c8);
        chk("cnt_sat_8",    int'(bus8.cnt_sat),    int'(e.s8));
        chk("sig_level_2",  int'(bus2.sig_level),  int'(e.lvl));
        chk("rise_pulse_2", int'(bus2.rise_pulse), int'(e.rise));
        chk("fall_pulse_2", int'(bus2.fall_pulse), int'(e.fall));
        chk("event_cnt_2",  int'(bus2.event_cnt),  e.c2);
        chk("cnt_sat_2",    int'(bus2.cnt_sat),    int'(e.s2));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", mon_cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    d_rst_n = 1'b0;
    sig_in  = 1'b1;
    cnt_clr = 1'b1;

    // Reset with inputs active, then a clean rise.
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    run(6, 1'b1);
    run(6, 1'b0);

    // Short high run: discarded.
    run(3, 1'b1);
    run(6, 1'b0);

    // High period with a 2-cycle low glitch, then a real fall.
    run(5, 1'b1);
    run(2, 1'b0);
    run(5, 1'b1);
    run(10, 1'b0);

    // Five clean pulses saturate the 2-bit counter.
    for (int p = 0; p < 5; p++) begin
      run(5, 1'b1);
      run(5, 1'b0);
    end

    // Clear on the confirming edge keeps the event; clear alone zeroes.
    run(3, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    run(5, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    run(2, 1'b0);

    // Reset while high: level drops silently, new rise after release.
    run(6, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    run(6, 1'b1);
    run(6, 1'b0);

    // Randomized runs with occasional clears and resets.
    for (int k = 0; k < 400; k++) begin
      int len;
      bit lv;
      len = $urandom_range(1, 7);
      lv  = 1'($urandom_range(0, 1));
      for (int j = 0; j < len; j++) begin
        cyc(1'($urandom_range(0, 299) != 0), lv, 1'($urandom_range(0, 39) == 0));
      end
    end

    // Many minimum-spacing pulses to saturate the 8-bit counter.
    for (int p = 0; p < 260; p++) begin
      run(S, 1'b1);
      run(S, 1'b0);
    end
    run(3, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    run(6, 1'b0);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge d_clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
